regfile: RTL and testbench

General-purpose register file for the five-stage MIPS core: 32 × 32-bit registers with two combinational read ports serving the decode stage and one synchronous write port driven by write-back. It also holds the HI/LO register pair written by write-back and read by execute. Register $0 is hard-wired to zero. A write-to-read bypass lets decode see a value being written back in the same cycle.

---
 rtl/regfile.sv | 98 +++++++++
 tb/tb_regfile.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: 31 x 32-bit general-purpose registers ($0 hard-wired to zero),
// two combinational read ports with same-cycle write bypass, one write port,
// and a registered HI/LO pair.
module regfile #(
    localparam int unsigned REG_W    = 32,
    localparam int unsigned ADDR_W   = 5,
    localparam int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [REG_W-1:0]  wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [REG_W-1:0]  rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [REG_W-1:0]  rdata2,
    input  logic              hilo_we,
    input  logic [REG_W-1:0]  hi_i,
    input  logic [REG_W-1:0]  lo_i,
    output logic [REG_W-1:0]  hi_o,
    output logic [REG_W-1:0]  lo_o
);

    // Register 0 has no storage; only 1..31 are flops.
    logic [REG_W-1:0] regs_q [1:NUM_REGS-1];
    logic [REG_W-1:0] regs_d [1:NUM_REGS-1];
    logic [REG_W-1:0] hi_q, hi_d;
    logic [REG_W-1:0] lo_q, lo_d;

    // Next-state for the register array: a write to $0 is dropped.
    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    // Next-state for HI/LO: always updated as a pair.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hilo_we) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    // State update; synchronous reset wins over any simultaneous write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Read port 1: zero in reset, for $0 or when disabled; bypass an in-flight write.
    always_comb begin
        rdata1 = '0;
        if (rst && (raddr1 != '0) && re1) begin
            if (we && (raddr1 == waddr)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs_q[raddr1];
            end
        end
    end

    // Read port 2: same rules as port 1, fully independent.
    always_comb begin
        rdata2 = '0;
        if (rst && (raddr2 != '0) && re2) begin
            if (we && (raddr2 == waddr)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs_q[raddr2];
            end
        end
    end

    // HI/LO expose stored values only; execute-stage forwarding covers in-flight data.
    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scenarios plus randomized traffic against a
// behavioural array model of the register file.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        hilo_we;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] mdl [0:31];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .hilo_we(hilo_we),
        .hi_i   (hi_i),
        .lo_i   (lo_i),
        .hi_o   (hi_o),
        .lo_o   (lo_o)
    );

    // Apply the current inputs to the model, then advance one clock edge.
    task automatic tick();
        if (!rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
            m_hi = 32'h0;
            m_lo = 32'h0;
        end else begin
            if (we && waddr != 5'd0) mdl[waddr] = wdata;
            if (hilo_we) begin
                m_hi = hi_i;
                m_lo = lo_i;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Expected read value from the priority rules.
    function automatic logic [31:0] exp_rd(input logic r, input logic [4:0] a);
        if (!rst) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (r && we && a == waddr) return wdata;
        if (r) return mdl[a];
        return 32'h0;
    endfunction

    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
        hilo_we = 1'b0; hi_i = 32'h0; lo_i = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        hilo_we = 1'b1; hi_i = 32'hCAFE0001; lo_i = 32'hCAFE0002;
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata_low: got %h want %h", rdata1, 32'h0);
        end
        tick();
        tick();
        rst = 1'b1;
        we = 1'b0; hilo_we = 1'b0;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL reset_reg5: got %h want %h", rdata1, 32'h0);
        end
        n_checks++;
        if (hi_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_hi: got %h want %h", hi_o, 32'h0);
        end
        n_checks++;
        if (lo_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_lo: got %h want %h", lo_o, 32'h0);
        end
    endtask

    task automatic test_write_read();
        idle();
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
        tick();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd7;
        #1;
        n_checks++;
        if (rdata1 !== 32'h1234_5678) begin
            n_fail++; $display("FAIL write_read_r7: got %h want %h", rdata1, 32'h1234_5678);
        end
        idle();
        we = 1'b1; waddr = 5'd31; wdata = 32'hA5A5_0000;
        tick();
        we = 1'b0; re2 = 1'b1; raddr2 = 5'd31;
        #1;
        n_checks++;
        if (rdata2 !== 32'hA5A5_0000) begin
            n_fail++; $display("FAIL write_read_r31: got %h want %h", rdata2, 32'hA5A5_0000);
        end
        re1 = 1'b1; raddr1 = 5'd7;
        #1;
        n_checks++;
        if (rdata1 !== 32'h1234_5678) begin
            n_fail++; $display("FAIL write_read_r7_kept: got %h want %h", rdata1, 32'h1234_5678);
        end
    endtask

    task automatic test_bypass();
        idle();
        we = 1'b1; waddr = 5'd3; wdata = 32'h1;
        tick();
        wdata = 32'h2;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
        #1;
        n_checks++;
        if (rdata1 !== 32'h2) begin
            n_fail++; $display("FAIL bypass_p1: got %h want %h", rdata1, 32'h2);
        end
        n_checks++;
        if (rdata2 !== 32'h2) begin
            n_fail++; $display("FAIL bypass_p2: got %h want %h", rdata2, 32'h2);
        end
        re1 = 1'b0;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL bypass_re_off: got %h want %h", rdata1, 32'h0);
        end
        tick();
        we = 1'b0; re1 = 1'b1;
        #1;
        n_checks++;
        if (rdata1 !== 32'h2) begin
            n_fail++; $display("FAIL bypass_stored: got %h want %h", rdata1, 32'h2);
        end
    endtask

    task automatic test_zero();
        idle();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL zero_write_cycle: got %h want %h", rdata1, 32'h0);
        end
        tick();
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL zero_after: got %h want %h", rdata1, 32'h0);
        end
    endtask

    task automatic test_hilo();
        idle();
        hilo_we = 1'b1; hi_i = 32'hAA; lo_i = 32'hBB;
        tick();
        hi_i = 32'h11; lo_i = 32'h22;
        #1;
        n_checks++;
        if (hi_o !== 32'hAA || lo_o !== 32'hBB) begin
            n_fail++; $display("FAIL hilo_before_edge: got %h/%h want %h/%h", hi_o, lo_o, 32'hAA, 32'hBB);
        end
        tick();
        n_checks++;
        if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
            n_fail++; $display("FAIL hilo_after_edge: got %h/%h want %h/%h", hi_o, lo_o, 32'h11, 32'h22);
        end
        hilo_we = 1'b0; hi_i = 32'h33; lo_i = 32'h44;
        tick();
        n_checks++;
        if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
            n_fail++; $display("FAIL hilo_no_we: got %h/%h want %h/%h", hi_o, lo_o, 32'h11, 32'h22);
        end
    endtask

    task automatic test_reset_collision();
        idle();
        we = 1'b1; waddr = 5'd9; wdata = 32'h55;
        tick();
        rst = 1'b0; wdata = 32'h77;
        hilo_we = 1'b1; hi_i = 32'h99; lo_i = 32'h98;
        tick();
        rst = 1'b1;
        we = 1'b1; waddr = 5'd10; wdata = 32'h66; hilo_we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd9;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL collision_r9: got %h want %h", rdata1, 32'h0);
        end
        n_checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
            n_fail++; $display("FAIL collision_hilo: got %h/%h want 0/0", hi_o, lo_o);
        end
        tick();
        we = 1'b0; raddr1 = 5'd10;
        #1;
        n_checks++;
        if (rdata1 !== 32'h66) begin
            n_fail++; $display("FAIL release_first_write: got %h want %h", rdata1, 32'h66);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h0000_1111; vals[1] = 32'h0000_2222; vals[2] = 32'h0000_3333;
        idle();
        re2 = 1'b1; raddr2 = 5'd12;
        for (int k = 0; k < 3; k++) begin
            we = 1'b1; waddr = 5'd12; wdata = vals[k];
            #1;
            n_checks++;
            if (rdata2 !== vals[k]) begin
                n_fail++; $display("FAIL b2b_bypass_%0d: got %h want %h", k, rdata2, vals[k]);
            end
            tick();
        end
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata2 !== 32'h0000_3333) begin
            n_fail++; $display("FAIL b2b_last_wins: got %h want %h", rdata2, 32'h0000_3333);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 31) != 0);
            we      = $urandom_range(0, 3) != 0;
            waddr   = 5'($urandom_range(0, 9));
            wdata   = $urandom;
            re1     = $urandom_range(0, 7) != 0;
            raddr1  = 5'($urandom_range(0, 9));
            re2     = $urandom_range(0, 7) != 0;
            raddr2  = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
            hilo_we = $urandom_range(0, 1) != 0;
            hi_i    = $urandom;
            lo_i    = $urandom;
            #1;
            e1 = exp_rd(re1, raddr1);
            e2 = exp_rd(re2, raddr2);
            n_checks++;
            if (rdata1 !== e1) begin
                n_fail++; $display("FAIL rand_rdata1 c=%0d: got %h want %h", c, rdata1, e1);
            end
            n_checks++;
            if (rdata2 !== e2) begin
                n_fail++; $display("FAIL rand_rdata2 c=%0d: got %h want %h", c, rdata2, e2);
            end
            n_checks++;
            if (hi_o !== m_hi || lo_o !== m_lo) begin
                n_fail++; $display("FAIL rand_hilo c=%0d: got %h/%h want %h/%h", c, hi_o, lo_o, m_hi, m_lo);
            end
            tick();
        end
        rst = 1'b1;
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero();
        test_hilo();
        test_reset_collision();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
